// File: rtl/riscv_fetch_pkg.sv
// Shared constants, entry layout and width helper for the riscv instruction-fetch front end.
// Optional feature macro used by the top: RISCV_FETCH_MISALIGN_EN.
package riscv_fetch_pkg;

  localparam int                  DEF_XLEN     = 32;
  localparam int                  PC_STEP      = 4;
  localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = '0;

  typedef struct packed {
    logic                misalign;
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_XLEN-1:0] instr;
  } fetch_entry_t;

  // Width able to hold 0..depth inclusive (counts and credits).
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous prefetch FIFO with flush; a push in the flush cycle lands as the sole new entry.
module riscv_fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  input  logic                        flush,
  output logic [WIDTH-1:0]            rdata,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [PW-1:0]    waddr;

  assign waddr = flush ? '0 : wptr_q;
  assign rdata = mem[rptr_q];

  always_ff @(posedge clk) begin
    if (push) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count  <= '0;
    end else if (flush) begin
      rptr_q <= '0;
      wptr_q <= push ? PW'(1) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: in-order imem requests, prefetch FIFO, redirect with flush.
// Define RISCV_FETCH_MISALIGN_EN to turn misaligned redirect targets into a marker entry.
module riscv_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN       = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] fetch_instr,
  output logic            fetch_misalign
);

  localparam int              CW   = cnt_width(FIFO_DEPTH);
  localparam int              EW   = 2 * XLEN + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] pc_q, pc_tag_q, target;
  logic [CW-1:0]   outstanding_q, outstanding_d, discard_q, fifo_count;
  logic [CW:0]     credit_used;
  logic            halted_q, fire, push, pop, target_misalign;
  logic [EW-1:0]   push_data, head;

`ifdef RISCV_FETCH_MISALIGN_EN
  assign target          = redirect_pc;
  assign target_misalign = |redirect_pc[1:0];
`else
  assign target          = redirect_pc & ~XLEN'(3);
  assign target_misalign = 1'b0;
`endif

  // Credit covers in-flight requests plus buffered entries, so every response has a FIFO slot.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req    = !reset && !redirect_valid && !halted_q &&
                       (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr   = pc_q;
  assign fire        = imem_req && imem_gnt;

  // Handshakes: imem transfers when imem_req && imem_gnt; decode takes the head when
  // fetch_valid && fetch_ready, except in a redirect cycle where that pop is void.
  assign pop = fetch_valid && fetch_ready && !redirect_valid;

  always_comb begin
    outstanding_d = outstanding_q;
    if (fire && !imem_rvalid)      outstanding_d = outstanding_q + CW'(1);
    else if (!fire && imem_rvalid) outstanding_d = outstanding_q - CW'(1);
  end

  always_comb begin
    push      = 1'b0;
    push_data = {1'b0, pc_tag_q, imem_rdata};
    if (redirect_valid) begin
      push      = target_misalign;
      push_data = {target_misalign, target, {XLEN{1'b0}}};
    end else if (imem_rvalid && discard_q == '0) begin
      push = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      pc_tag_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      halted_q      <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        pc_q      <= target;
        pc_tag_q  <= target;
        discard_q <= outstanding_d;
        halted_q  <= target_misalign;
      end else begin
        if (fire) pc_q <= pc_q + STEP;
        if (imem_rvalid) begin
          if (discard_q != '0) discard_q <= discard_q - CW'(1);
          else                 pc_tag_q  <= pc_tag_q + STEP;
        end
      end
    end
  end

  riscv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .flush (redirect_valid),
    .rdata (head),
    .count (fifo_count)
  );

  assign fetch_valid    = (fifo_count != '0);
  assign fetch_pc       = fetch_valid ? head[2*XLEN-1:XLEN] : '0;
  assign fetch_instr    = fetch_valid ? head[XLEN-1:0] : '0;
  assign fetch_misalign = fetch_valid && head[EW-1];

  rvalid_without_request: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && outstanding_q == '0));

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: random-latency in-order memory, random stall/redirect,
// scoreboard of expected fetch addresses checked against decode-side output.
module tb_riscv_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid, fetch_ready, fetch_misalign;
  logic [31:0] fetch_pc, fetch_instr;

  riscv_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .fetch_instr    (fetch_instr),
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  // Scoreboard: addresses granted on the current path, in the order decode must see them.
  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_addr;
  bit          halted_exp;
  int          cyc, grants, pops;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        s_req, s_valid, s_pop, s_mis;
  logic [31:0] s_addr, s_pc, s_pop_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fetch_ready    = 1'b0;
    exp_q.delete();
    pend_addr.delete();
    pend_due.delete();
    exp_addr   = 32'h0;
    halted_exp = 1'b0;
    grants     = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
  endtask

  // One cycle: drive at the negedge, sample #1 later, update model, wait for next negedge.
  task automatic step(input bit rdy, input bit gnt, input bit redir, input logic [31:0] tgt,
                      input int lat);
    logic [31:0] front;
    fetch_ready    = rdy;
    imem_gnt       = gnt;
    redirect_valid = redir;
    redirect_pc    = tgt;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = fetch_valid;
    s_pc = fetch_pc; s_mis = fetch_misalign; s_pop = 1'b0;
    if (redir || halted_exp) chk("req_blocked", 32'(imem_req), 32'd0);
    if (imem_req) chk("req_addr", imem_addr, exp_addr);
    if (fetch_valid && rdy && !redir) begin
      chk("pop_has_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        front = exp_q.pop_front();
        chk("pop_pc", fetch_pc, front);
        chk("pop_misalign", 32'(fetch_misalign), 32'(front[1:0] != 2'b00));
        chk("pop_instr", fetch_instr, (front[1:0] != 2'b00) ? 32'h0 : memf(front));
      end
      s_pop = 1'b1; s_pop_pc = fetch_pc; pops++;
    end
    if (imem_req && gnt) begin
      chk("credit", 32'(exp_q.size() < DEPTH), 32'd1);
      exp_q.push_back(exp_addr);
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + lat);
      exp_addr += 32'd4;
      grants++;
    end
    if (redir) begin
      exp_q.delete();
`ifdef RISCV_FETCH_MISALIGN_EN
      if (tgt[1:0] != 2'b00) begin
        exp_q.push_back(tgt);
        halted_exp = 1'b1;
      end else begin
        exp_addr   = tgt;
        halted_exp = 1'b0;
      end
`else
      exp_addr = tgt & ~32'd3;
`endif
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int p0;
    bit found;
    pops  = 0;
    reset = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; fetch_ready = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_pc", fetch_pc, 32'd0);
    chk("rst_instr", fetch_instr, 32'd0);
    chk("rst_misalign", 32'(fetch_misalign), 32'd0);

    // Zero-wait memory, decode always ready: first valid two cycles in, then one per cycle.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, '0, 1);
      if (i == 0) chk("first_req", 32'(s_req), 32'd1);
      chk("valid_timing", 32'(s_valid), 32'(i >= 2));
    end

    // Decode stalled for 10 cycles: credit allows exactly DEPTH grants.
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 1, 0, '0, 1);
    chk("stall_grants", 32'(grants), 32'(DEPTH));
    chk("stall_req_off", 32'(s_req), 32'd0);
    p0 = pops;
    for (int i = 0; i < 4; i++) step(1, 1, 0, '0, 1);
    chk("resume_pops", 32'(pops - p0), 32'd4);

    // Slow memory, three requests in flight when the redirect arrives.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, '0, 4);
    step(1, 1, 1, 32'h100, 4);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1, 1, 0, '0, 4);
      if (s_pop) begin
        found = 1'b1;
        chk("redirect_head", s_pop_pc, 32'h100);
      end
    end
    chk("redirect_head_seen", 32'(found), 32'd1);

    // Redirect landing on a cycle with a valid head, ready and gnt high.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 1, 0, '0, 1);
    step(1, 1, 1, 32'h40, 1);
    chk("redir_with_head", 32'(s_valid), 32'd1);
    step(1, 1, 0, '0, 1);
    chk("redir_flushed", 32'(s_valid), 32'd0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, '0, 1);

`ifdef RISCV_FETCH_MISALIGN_EN
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 0, '0, 1);
    step(1, 1, 1, 32'h102, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, '0, 1);
      chk("mis_req_off", 32'(s_req), 32'd0);
      chk("mis_valid", 32'(s_valid), 32'd1);
      chk("mis_flag", 32'(s_mis), 32'd1);
      chk("mis_pc", s_pc, 32'h102);
    end
    step(1, 1, 0, '0, 1);
    step(1, 1, 1, 32'h200, 1);
    for (int i = 0; i < 8; i++) step(1, 1, 0, '0, 1);
`endif

    // Asynchronous reset with a full FIFO.
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 1, 0, '0, 1);
    chk("full_before_reset", 32'(s_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(fetch_valid), 32'd0);
    chk("async_rst_req", 32'(imem_req), 32'd0);
    chk("async_rst_pc", fetch_pc, 32'd0);
    chk("async_rst_instr", fetch_instr, 32'd0);
    do_reset();
    step(1, 1, 0, '0, 1);
    chk("restart_req", 32'(s_req), 32'd1);
    chk("restart_addr", s_addr, 32'h0);

    // Random stall, grant, latency and redirect traffic.
    do_reset();
    p0 = pops;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
           $urandom, $urandom_range(1, 4));
    end
    chk("random_progress", 32'(pops - p0 > 300), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
